mmio_bus_decoder: RTL and testbench

- Parametrised memory-mapped bus decoder between the multi-cycle MIPS core's load/store port and N_SLAVES peripherals: data memory, IO block, seven-segment controller and future devices.
- Successor to the fixed two-way addr[7] split.
- Adds a registered request/ready handshake per slave, unmapped-address and timeout error detection, and a saturating error counter.
- Sits between the core's memory interface and the slave instances at top level.

---
 rtl/mmio_bus_decoder_if.sv | 36 +++
 rtl/mmio_bus_decoder.sv | 149 ++++++++++++++
 tb/tb_mmio_bus_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_decoder_if.sv
// Signal bundle between the core's load/store port, the MMIO decoder and its slave ports.
// The "master" view is the environment (core plus slaves); "slave" is the decoder's own view.
interface mmio_bus_decoder_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4
);
    logic                         cpu_req;
    logic                         cpu_we;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [DATA_W-1:0]            cpu_wdata;
    logic [DATA_W-1:0]            cpu_rdata;
    logic                         cpu_ready;
    logic                         cpu_err;
    logic [7:0]                   err_count;
    logic [N_SLAVES-1:0]          s_req;
    logic                         s_we;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [N_SLAVES*DATA_W-1:0]   s_rdata;
    logic [N_SLAVES-1:0]          s_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err, err_count,
        input  s_req, s_we, s_addr, s_wdata,
        output s_rdata, s_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err, err_count,
        output s_req, s_we, s_addr, s_wdata,
        input  s_rdata, s_ready
    );
endinterface

// File: rtl/mmio_bus_decoder.sv
// Memory-mapped decoder: routes one core access at a time to a slave selected by an address
// field, with per-slave request/ready handshake, unmapped/timeout errors and an error counter.
module mmio_bus_decoder #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_LSB  = 7,
    parameter int SEL_W    = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    mmio_bus_decoder_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    state_t              state_next;
    logic [SEL_W-1:0]    sel;
    logic                sel_mapped;
    logic [N_SLAVES-1:0] sel_onehot;
    logic [N_SLAVES-1:0] req;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                ready;
    logic                err;
    logic [7:0]          err_cnt;
    logic [CNT_W-1:0]    cnt;
    logic                slave_ready;
    logic [DATA_W-1:0]   slave_rdata;
    logic                timed_out;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign sel        = bus.cpu_addr[SEL_LSB +: SEL_W];
    assign sel_mapped = (32'(sel) < N_SLAVES);
    assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_onehot[i] = (32'(sel) == i);
        end
    end

    // The registered one-hot request doubles as the response mux select, so ready and read
    // data from slaves that are not being addressed never reach the core.
    always_comb begin
        slave_ready = 1'b0;
        slave_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (req[i]) begin
                slave_ready = bus.s_ready[i];
                slave_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.cpu_req) state_next = sel_mapped ? ACCESS : RESP;
            ACCESS:  if (slave_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response fields are loaded on the edge that enters RESP, so cpu_ready is high exactly
    // while the FSM sits in RESP and a request still held there is not re-sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req     <= '0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            cnt     <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        we    <= bus.cpu_we;
                        addr  <= bus.cpu_addr;
                        wdata <= bus.cpu_wdata;
                        cnt   <= '0;
                        if (sel_mapped) begin
                            req <= sel_onehot;
                        end else begin
                            ready   <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= '0;
                            err_cnt <= sat_inc8(err_cnt);
                        end
                    end
                end
                ACCESS: begin
                    if (slave_ready) begin
                        req   <= '0;
                        ready <= 1'b1;
                        err   <= 1'b0;
                        rdata <= we ? '0 : slave_rdata;
                    end else if (timed_out) begin
                        req     <= '0;
                        ready   <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                        err_cnt <= sat_inc8(err_cnt);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    cnt <= '0;
                end
                default: begin
                    req <= '0;
                end
            endcase
        end
    end

    assign bus.cpu_rdata = rdata;
    assign bus.cpu_ready = ready;
    assign bus.cpu_err   = err;
    assign bus.err_count = err_cnt;
    assign bus.s_req     = req;
    assign bus.s_we      = we;
    assign bus.s_addr    = addr;
    assign bus.s_wdata   = wdata;
endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Bench for mmio_bus_decoder with three slaves (so select value 3 is unmapped) and TIMEOUT=15.
// Behavioural slaves answer after a programmed number of request cycles; unaddressed slaves toggle ready.
module tb_mmio_bus_decoder;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 3;
    localparam int TO  = 15;
    localparam int SL  = 7;
    localparam int SW  = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] srd;
        int            e_lat;
        logic          e_err;
        logic [DW-1:0] e_rd;
        logic [NS-1:0] e_req;
        int            e_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   model_errs = 0;
    bit   noise_hi = 0;

    int            slv_lat[NS];
    logic [DW-1:0] slv_rd[NS];
    int            slv_cyc[NS] = '{default: 0};

    mmio_bus_decoder_if #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS)) bus ();

    mmio_bus_decoder #(
        .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS),
        .SEL_LSB(SL), .SEL_W(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Slave i raises ready in its lat-th requested cycle (lat 0 = never answers).
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (bus.s_req[i] === 1'b1) begin
                slv_cyc[i]++;
                bus.s_ready[i] = (slv_lat[i] != 0) && (slv_cyc[i] == slv_lat[i]);
            end else begin
                slv_cyc[i] = 0;
                bus.s_ready[i] = noise_hi ? 1'b1 : 1'($urandom_range(0, 1));
            end
            bus.s_rdata[i*DW +: DW] = slv_rd[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sel_of(input logic [AW-1:0] a);
        return int'(a[SL +: SW]);
    endfunction

    // Expected outcome from the decoder's rules: unmapped -> 1 cycle error; slave answering
    // within TIMEOUT cycles -> lat+1, read data (0 for writes); otherwise TIMEOUT+1 error.
    function automatic vec_t model(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                                   input int lat, input logic [DW-1:0] rd);
        vec_t v;
        int   s;
        s = sel_of(a);
        v.addr = a; v.we = w; v.wdata = wd; v.lat = lat; v.srd = rd;
        if (s >= NS) begin
            v.e_lat = 1; v.e_err = 1'b1; v.e_rd = '0; v.e_req = '0; v.e_cyc = 0;
        end else if (lat >= 1 && lat <= TO) begin
            v.e_lat = lat + 1; v.e_err = 1'b0; v.e_rd = w ? '0 : rd;
            v.e_req = NS'(1 << s); v.e_cyc = lat;
        end else begin
            v.e_lat = TO + 1; v.e_err = 1'b1; v.e_rd = '0;
            v.e_req = NS'(1 << s); v.e_cyc = TO;
        end
        return v;
    endfunction

    // Called at a negedge where the next rising edge samples the decoder in IDLE.
    task automatic run_txn(input string name, input vec_t v, input bit keep);
        int cyc, req_cyc;
        bit got, bad_req, unstable;
        for (int i = 0; i < NS; i++) begin
            slv_lat[i] = v.lat;
            slv_rd[i]  = (i == sel_of(v.addr)) ? v.srd : $urandom;
        end
        bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
        cyc = 0; req_cyc = 0; got = 0; bad_req = 0; unstable = 0;
        while (!got && cyc < TO + 8) begin
            @(negedge clk);
            cyc++;
            if (bus.s_req !== '0) begin
                req_cyc++;
                if (bus.s_req !== v.e_req) bad_req = 1;
                if (bus.s_addr !== v.addr || bus.s_wdata !== v.wdata || bus.s_we !== v.we)
                    unstable = 1;
            end
            if (bus.cpu_ready === 1'b1) got = 1;
            else begin
                bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
                bus.cpu_we = 1'($urandom_range(0, 1));
            end
        end
        if (v.e_err) model_errs++;
        check({name, ".ready"}, 64'(got), 64'd1);
        check({name, ".latency"}, 64'(cyc), 64'(v.e_lat));
        check({name, ".err"}, 64'(bus.cpu_err), 64'(v.e_err));
        check({name, ".rdata"}, 64'(bus.cpu_rdata), 64'(v.e_rd));
        check({name, ".req_cycles"}, 64'(req_cyc), 64'(v.e_cyc));
        check({name, ".req_onehot_bad"}, 64'(bad_req), 64'd0);
        check({name, ".latched_unstable"}, 64'(unstable), 64'd0);
        check({name, ".err_count"}, 64'(bus.err_count), 64'((model_errs > 255) ? 255 : model_errs));
        if (keep) begin
            bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
        end else begin
            bus.cpu_req = 1'b0;
        end
        @(negedge clk);
        check({name, ".ready_pulse"}, 64'(bus.cpu_ready), 64'd0);
        check({name, ".gap_no_req"}, 64'(bus.s_req), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        bit   seen;

        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 1, 32'h1234_5678, 2, 1'b0, 32'h1234_5678, 3'b001, 1};
        vecs[1] = '{32'h0000_0084, 1'b1, 32'hCAFE_F00D, 3, 32'h5555_AAAA, 4, 1'b0, 32'h0, 3'b010, 3};
        vecs[2] = '{32'h0000_0180, 1'b0, 32'h0, 1, 32'h0, 1, 1'b1, 32'h0, 3'b000, 0};
        vecs[3] = '{32'h0000_0100, 1'b0, 32'h0, 0, 32'h7777_7777, 16, 1'b1, 32'h0, 3'b100, 15};
        vecs[4] = '{32'h0000_0104, 1'b0, 32'h0, 15, 32'hA5A5_0001, 16, 1'b0, 32'hA5A5_0001, 3'b100, 15};
        vecs[5] = '{32'h0000_0080, 1'b0, 32'h0, 14, 32'h1357_9BDF, 15, 1'b0, 32'h1357_9BDF, 3'b010, 14};
        vecs[6] = '{32'hFFFF_FF80, 1'b1, 32'h0000_0001, 1, 32'h0, 1, 1'b1, 32'h0, 3'b000, 0};
        vecs[7] = '{32'hDEAD_BE00, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 3, 1'b0, 32'h0BAD_F00D, 3'b001, 2};
        vecs[8] = '{32'h0000_0100, 1'b1, 32'h1111_2222, 16, 32'h9, 16, 1'b1, 32'h0, 3'b100, 15};

        for (int i = 0; i < NS; i++) begin
            slv_lat[i] = 0; slv_rd[i] = '0;
        end
        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset.cpu_ready", 64'(bus.cpu_ready), 64'd0);
        check("reset.cpu_err", 64'(bus.cpu_err), 64'd0);
        check("reset.cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        check("reset.err_count", 64'(bus.err_count), 64'd0);
        check("reset.s_req", 64'(bus.s_req), 64'd0);
        check("reset.s_we", 64'(bus.s_we), 64'd0);
        check("reset.s_addr", 64'(bus.s_addr), 64'd0);
        check("reset.s_wdata", 64'(bus.s_wdata), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Back-to-back: request held through RESP; unaddressed slaves hold ready high.
        noise_hi = 1;
        v = model(32'h0000_0020, 1'b0, 32'h0, 3, 32'h0F0F_1234);
        run_txn("b2b_first", v, 1'b1);
        run_txn("b2b_second", v, 1'b0);
        noise_hi = 0;

        // Asynchronous reset in the middle of an access.
        for (int i = 0; i < NS; i++) slv_lat[i] = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0080; bus.cpu_wdata = 32'h600D_D00D;
        repeat (3) @(negedge clk);
        check("midreset.s_req_before", 64'(bus.s_req), 64'b010);
        reset = 1'b0;
        #1;
        check("midreset.s_req", 64'(bus.s_req), 64'd0);
        check("midreset.err_count", 64'(bus.err_count), 64'd0);
        check("midreset.s_addr", 64'(bus.s_addr), 64'd0);
        check("midreset.s_wdata", 64'(bus.s_wdata), 64'd0);
        check("midreset.s_we", 64'(bus.s_we), 64'd0);
        check("midreset.cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        bus.cpu_req = 1'b0;
        model_errs = 0;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cpu_ready !== 1'b0 || bus.s_req !== '0) seen = 1;
        end
        check("midreset.no_response", 64'(seen), 64'd0);
        v = model(32'h0000_0004, 1'b0, 32'h0, 1, 32'h4242_4242);
        run_txn("after_reset", v, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int          r, lat;
            logic [AW-1:0] a;
            a = $urandom;
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(1, 5);
            v = model(a, 1'($urandom_range(0, 1)), $urandom, lat, $urandom);
            run_txn($sformatf("rnd%0d", n), v, 1'b0);
        end

        // Drive the error counter well past saturation with timeouts on slave 2.
        for (int n = 0; n < 256; n++) begin
            v = model(32'h0000_0100, 1'($urandom_range(0, 1)), $urandom, 0, $urandom);
            run_txn($sformatf("sat%0d", n), v, 1'b0);
        end
        check("sat.err_count", 64'(bus.err_count), 64'd255);
        v = model(32'h0000_0180, 1'b0, 32'h0, 1, 32'h0);
        run_txn("sat_unmapped", v, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
